// File: rtl/timer_mc.sv
// Multi-channel APB timer: NCH prescaled up-counters with compare match,
// one-shot/periodic mode, debug halt and a shared interrupt enable/status block.
module timer_mc #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32,
    parameter int DIV_W = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             dbg_mode,
    input  logic             tim_psel,
    input  logic             tim_penable,
    input  logic             tim_pwrite,
    input  logic [11:0]      tim_paddr,
    input  logic [31:0]      tim_pwdata,
    input  logic [3:0]       tim_pstrb,
    output logic [31:0]      tim_prdata,
    output logic             tim_pready,
    output logic             tim_pslverr,
    output logic [NCH-1:0]   tim_int_ch,
    output logic             tim_int
);

    localparam logic [7:0] ID_NCH  = 8'(NCH);
    localparam logic [7:0] ID_CNTW = 8'(CNT_W);

    logic             access;
    logic [1:0]       reg_sel;
    logic [3:0]       ch_idx;
    logic             is_glob;
    logic             is_chan;
    logic             err;
    logic             wr;
    logic [31:0]      wmask;
    logic [31:0]      rd_val;

    logic             gen;
    logic [NCH-1:0]   int_en;
    logic [NCH-1:0]   int_st;
    logic [NCH-1:0]   hw_set;
    logic [NCH-1:0]   w1c;
    logic             gctrl_wr;
    logic             inten_wr;
    logic             intst_wr;

    logic [31:0]      ctrl_rd [NCH];
    logic [31:0]      cmp_rd  [NCH];
    logic [31:0]      cnt_rd  [NCH];

    logic             unused_addr;

    function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign unused_addr = ^tim_paddr[1:0];

    // APB decode: globals live in 0x000-0x00C, channels at 0x100 + 0x10*ch
    assign access  = tim_psel & tim_penable;
    assign reg_sel = tim_paddr[3:2];
    assign ch_idx  = tim_paddr[7:4];
    assign is_glob = (tim_paddr[11:8] == 4'h0) && (tim_paddr[7:4] == 4'h0);
    assign is_chan = (tim_paddr[11:8] == 4'h1) && ({28'd0, ch_idx} < 32'(NCH))
                     && (reg_sel != 2'd3);
    assign err     = ~(is_glob | is_chan) | (tim_pwrite & is_glob & (reg_sel == 2'd3));
    assign wr      = access & tim_pwrite & ~err & (|tim_pstrb);
    assign wmask   = {{8{tim_pstrb[3]}}, {8{tim_pstrb[2]}},
                      {8{tim_pstrb[1]}}, {8{tim_pstrb[0]}}};

    assign gctrl_wr = wr & is_glob & (reg_sel == 2'd0);
    assign inten_wr = wr & is_glob & (reg_sel == 2'd1);
    assign intst_wr = wr & is_glob & (reg_sel == 2'd2);
    assign w1c      = intst_wr ? (tim_pwdata[NCH-1:0] & wmask[NCH-1:0]) : '0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gen    <= 1'b0;
            int_en <= '0;
            int_st <= '0;
        end else begin
            if (gctrl_wr && wmask[0]) begin
                gen <= tim_pwdata[0];
            end
            if (inten_wr) begin
                int_en <= (int_en & ~wmask[NCH-1:0]) | (tim_pwdata[NCH-1:0] & wmask[NCH-1:0]);
            end
            // a hardware set in the same cycle as a W1C keeps the bit set
            int_st <= (int_st & ~w1c) | hw_set;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             en;
        logic             oneshot;
        logic             dbg_halt;
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] pc;
        logic [CNT_W-1:0] cmp;
        logic [CNT_W-1:0] cnt;
        logic             sel;
        logic             ctrl_wr;
        logic             cmp_wr;
        logic             cnt_wr;
        logic             run;
        logic             tick;
        logic             match;
        logic             pc_clr;
        logic [31:0]      ctrl_word;
        logic [31:0]      ctrl_new;
        logic [31:0]      cmp_new;
        logic [31:0]      cnt_new;
        logic             unused_ch;

        assign sel     = wr & is_chan & (ch_idx == 4'(c));
        assign ctrl_wr = sel & (reg_sel == 2'd0);
        assign cmp_wr  = sel & (reg_sel == 2'd1);
        assign cnt_wr  = sel & (reg_sel == 2'd2);

        assign ctrl_word = (32'(div) << 8) | {29'd0, dbg_halt, oneshot, en};
        assign ctrl_new  = merge32(ctrl_word, tim_pwdata, wmask);
        assign cmp_new   = merge32(32'(cmp), tim_pwdata, wmask);
        assign cnt_new   = merge32(32'(cnt), tim_pwdata, wmask);
        assign unused_ch = ^{ctrl_new, cmp_new, cnt_new};

        assign run    = gen & en & ~(dbg_mode & dbg_halt);
        // >= keeps the prescaler bounded if div is lowered below the running pc
        assign tick   = run & (pc >= div);
        // a CNT write in the same cycle suppresses both increment and match
        assign match  = tick & ~cnt_wr & (cnt == cmp);
        assign pc_clr = cnt_wr | cmp_wr | (ctrl_wr & ctrl_new[0] & ~en);

        assign hw_set[c]  = match;
        assign ctrl_rd[c] = ctrl_word;
        assign cmp_rd[c]  = 32'(cmp);
        assign cnt_rd[c]  = 32'(cnt);

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                en       <= 1'b0;
                oneshot  <= 1'b0;
                dbg_halt <= 1'b0;
                div      <= '0;
                pc       <= '0;
                cmp      <= '1;
                cnt      <= '0;
            end else begin
                if (ctrl_wr) begin
                    en       <= ctrl_new[0];
                    oneshot  <= ctrl_new[1];
                    dbg_halt <= ctrl_new[2];
                    div      <= ctrl_new[8 +: DIV_W];
                end
                // one-shot auto-clear overrides any concurrent APB write of en
                if (match && oneshot) begin
                    en <= 1'b0;
                end

                if (cmp_wr) begin
                    cmp <= cmp_new[CNT_W-1:0];
                end

                if (cnt_wr) begin
                    cnt <= cnt_new[CNT_W-1:0];
                end else if (tick) begin
                    cnt <= match ? '0 : cnt + CNT_W'(1);
                end

                if (pc_clr) begin
                    pc <= '0;
                end else if (run) begin
                    pc <= (pc >= div) ? '0 : pc + DIV_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (is_glob) begin
            case (reg_sel)
                2'd0:    rd_val = {31'd0, gen};
                2'd1:    rd_val = 32'(int_en);
                2'd2:    rd_val = 32'(int_st);
                default: rd_val = {16'h0, ID_CNTW, ID_NCH};
            endcase
        end else if (is_chan) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_idx == 4'(i)) begin
                    case (reg_sel)
                        2'd0:    rd_val = ctrl_rd[i];
                        2'd1:    rd_val = cmp_rd[i];
                        default: rd_val = cnt_rd[i];
                    endcase
                end
            end
        end
    end

    assign tim_pready  = access;
    assign tim_pslverr = access & err;
    assign tim_prdata  = (access & ~err & ~tim_pwrite) ? rd_val : 32'd0;

    assign tim_int_ch = int_st & int_en;
    assign tim_int    = |tim_int_ch;

endmodule

// File: doc/timer_mc.md
# timer_mc

Parametrised multi-channel successor to the single 64-bit APB timer. It provides NCH independent up-counters of CNT_W bits, each with its own prescaler, compare register, periodic/one-shot mode and debug-halt enable. Interrupts are per channel with a shared enable/status/W1C block, and the whole timer sits as one APB slave on the peripheral bus. A per-channel interrupt vector and an OR-combined interrupt go to the system interrupt controller.

## Interface
- NCH, 4, channel count, 1..8
- CNT_W, 32, counter/compare width, 8..32
- DIV_W, 8, prescaler divide-value width, 1..16
- sys_clk  in  1  clock; all logic on the rising edge
- sys_rst  in  1  synchronous, active-high reset
- dbg_mode  in  1  debug state from the core
- tim_psel, tim_penable, tim_pwrite  in  1  APB control
- tim_paddr  in  12  byte address; bits [1:0] are ignored
- tim_pwdata  in  32  write data
- tim_pstrb  in  4  byte strobes
- tim_prdata  out  32  read data
- tim_pready  out  1  transfer complete
- tim_pslverr  out  1  transfer error
- tim_int_ch  out  NCH  per-channel interrupt
- tim_int  out  1  OR of tim_int_ch

## Operation
- Global registers:
  - 0x000 GCTRL: bit0 gen, the global enable; reset 0.
  - 0x004 INT_EN: [NCH-1:0]; reset 0.
  - 0x008 INT_ST: [NCH-1:0], write-1-to-clear; reset 0.
  - 0x00C ID: read-only, {16'h0, CNT_W[7:0], NCH[7:0]}.
- Channel registers, base 0x100 + 0x10*ch:
  - +0x0 CTRL: bit0 en, bit1 oneshot, bit2 dbg_halt, bits[8+DIV_W-1:8] div. Reset 0.
  - +0x4 CMP: [CNT_W-1:0]; reset all-ones.
  - +0x8 CNT: [CNT_W-1:0]. Read returns the live count; write loads it.
- Unimplemented register bits read 0 and ignore writes.
- Writes honour tim_pstrb per byte. A strobe of 0 on a legal address is a no-op with no error.
- Error (tim_pslverr=1, no register change, tim_prdata=0) on:
  - any address outside the map;
  - a channel index ≥ NCH;
  - a write to ID.
- Channel run condition: gen & en & ~(dbg_mode & dbg_halt). When not running, the prescaler and counter hold their values.
- Prescaler: per-channel counter pc, 0..div. A tick occurs when running and pc==div; pc then returns to 0. div=0 gives a tick every cycle.
- On a tick:
  - If cnt==CMP: set INT_ST[ch] and set cnt←0. If oneshot=1, also clear en.
  - Otherwise cnt←cnt+1, wrapping modulo 2^CNT_W.
- Writing CNT or CMP, or writing en from 0→1, clears pc to 0.
- tim_int_ch = INT_ST & INT_EN; tim_int = |tim_int_ch. Both are combinational from flops, with no APB-path glitch.
- Simultaneous events:
  - APB CNT write and a tick in the same cycle: the write wins, no increment, no match evaluated.
  - Hardware set and W1C clear of the same INT_ST bit in the same cycle: the set wins.
  - APB write clearing en and a one-shot auto-clear in the same cycle: result en=0, flag set.
  - Changing CMP below the current cnt: no match until the count wraps.

## Timing
- APB access is zero-wait:
  - tim_pready = tim_psel & tim_penable.
  - tim_pslverr and tim_prdata are valid in the same access cycle, and are 0 when tim_pready is 0.
- A register write takes effect at the rising edge that ends the access phase. A read in the following access returns the new value.
- Count progression: with div=0, the counter advances 1 per cycle starting the cycle after gen&en are both seen high.
- Match timing: INT_ST[ch] and tim_int_ch rise at the same edge where cnt is reset to 0.
- Period:
  - Periodic mode, counter starting from 0: (CMP+1)*(div+1) cycles between flag sets.
  - Periodic mode, first period after a CNT load of V: (CMP-V+1)*(div+1) cycles.
- Reset (sys_rst high at an edge): all registers return to their reset values and pc=0. tim_int, tim_int_ch, tim_pslverr and tim_prdata are 0 in the following cycle. Reset mid-count discards the count, and reset overrides any concurrent APB write.
- Debug halt freezes pc and cnt in the cycle dbg_mode is high. Counting resumes with no lost or duplicated tick.

## Test plan
- Reset, then read ID with NCH=4, CNT_W=32 → 0x0000_2004. Read channel 0 CMP → 0xFFFF_FFFF. All outputs are 0.
- ch0: div=0, CMP=4, periodic, INT_EN=1, gen=1 → tim_int_ch[0] rises 5 cycles after enable. W1C 0x1 clears it, and it rises again 5 cycles after the previous rise.
- ch1: div=3, CMP=2, oneshot → flag sets after 12 cycles, CTRL.en reads 0, CNT reads 0 and stays 0.
- ch2: dbg_halt=1, with dbg_mode pulsed for 7 cycles mid-count → the flag is delayed by exactly 7 cycles. Repeat with dbg_halt=0 → no delay.
- Error and strobe checks:
  - Write to 0x140 (channel 4 when NCH=4) → tim_pslverr=1, no state change.
  - Write 0x1234_5678 to CMP with pstrb=0b0010 → CMP reads 0xFFFF_56FF.
- Same-cycle W1C of INT_ST[0] coinciding with a ch0 match → the bit stays 1. CNT write coinciding with a tick → CNT reads the written value.
